// File: rtl/capture_pkg.sv
// capture_pkg: shared FSM state, register map and CTRL bit positions for the capture block.
package capture_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_READ} state_t;
  localparam int A_CTRL = 0;
  localparam int A_MASK = 1;
  localparam int A_POST = 2;
  localparam int CTRL_ARM = 0;
  localparam int CTRL_ABORT = 1;
endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port synchronous RAM, one write port, one read port, 1-cycle read latency.
module capture_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/capture.sv
// capture: circular pre/post-trigger history RAM that freezes on a masked event and streams the window out.
// Define CAPTURE_EVENT_STORE_EN to store event flags alongside each sample.
module capture
  import capture_pkg::*;
#(
  parameter int BAW = 8,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int SEW = 32,
  parameter int MAW = 10
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SEW-1:0] sti_tevent,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic           sto_tlast,
  output logic [SEW-1:0] sto_tevent,
  output logic [SDW-1:0] sto_tdata,
  output logic           acq_busy,
  output logic           acq_irq
);
`ifdef CAPTURE_EVENT_STORE_EN
  localparam int RDW = SEW + SDW;
`else
  localparam int RDW = SDW;
`endif
  state_t         r_state;
  logic [MAW-1:0] r_wptr, r_rptr, r_cnt, r_ocnt, r_post, r_post_sh;
  logic [SEW-1:0] r_mask, r_mask_sh;
  logic           r_ovalid, r_irq;
  logic           w_ctrl, w_arm, w_abort, w_trig, w_we;
  logic [MAW-1:0] w_pre, w_cnt_nx, w_raddr;
  logic [RDW-1:0] w_wdata, w_rdata;
  assign w_ctrl   = bus_wvalid && bus_waddr == BAW'(A_CTRL);
  assign w_arm    = w_ctrl && bus_wdata[CTRL_ARM];
  assign w_abort  = w_ctrl && bus_wdata[CTRL_ABORT];
  assign w_trig   = |(sti_tevent & r_mask_sh);
  assign w_we     = sti_tvalid && (r_state == S_FILL || r_state == S_ARMED || r_state == S_POST);
  assign w_pre    = ~r_post_sh;
  assign w_cnt_nx = r_cnt + 1'b1;
  // Re-read the current beat while stalled so the RAM output doubles as the hold register.
  assign w_raddr  = r_ovalid ? r_rptr + MAW'(sto_tready) : r_wptr;
`ifdef CAPTURE_EVENT_STORE_EN
  assign w_wdata    = {sti_tevent, sti_tdata};
  assign sto_tevent = r_ovalid ? w_rdata[SDW+:SEW] : '0;
`else
  assign w_wdata    = sti_tdata;
  assign sto_tevent = '0;
`endif
  assign sto_tdata  = r_ovalid ? w_rdata[SDW-1:0] : '0;
  assign sto_tvalid = r_ovalid;
  assign sto_tlast  = r_ovalid && &r_ocnt;
  assign acq_busy   = r_state != S_IDLE;
  assign acq_irq    = r_irq;
  assign sti_tready = 1'b1;
  assign bus_wready = 1'b1;
  capture_ram #(.AW(MAW), .DW(RDW)) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_wptr),
    .i_wdata(w_wdata),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask <= '0;
      r_post <= '0;
    end else if (bus_wvalid) begin
      if (bus_waddr == BAW'(A_MASK)) r_mask <= bus_wdata[SEW-1:0];
      if (bus_waddr == BAW'(A_POST)) r_post <= bus_wdata[MAW-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_ocnt    <= '0;
      r_post_sh <= '0;
      r_mask_sh <= '0;
      r_ovalid  <= 1'b0;
      r_irq     <= 1'b0;
    end else if (w_abort) begin
      r_state  <= S_IDLE;
      r_ovalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        S_IDLE: if (w_arm) begin
          r_mask_sh <= r_mask;
          r_post_sh <= r_post;
          r_wptr    <= '0;
          r_cnt     <= '0;
          r_state   <= &r_post ? S_ARMED : S_FILL;
        end
        S_FILL: if (sti_tvalid) begin
          r_wptr <= r_wptr + 1'b1;
          r_cnt  <= w_cnt_nx;
          if (w_cnt_nx == w_pre) r_state <= S_ARMED;
        end
        S_ARMED: if (sti_tvalid) begin
          r_wptr <= r_wptr + 1'b1;
          r_cnt  <= '0;
          if (w_trig) begin
            r_irq   <= r_post_sh == '0;
            r_state <= r_post_sh == '0 ? S_READ : S_POST;
          end
        end
        S_POST: if (sti_tvalid) begin
          r_wptr <= r_wptr + 1'b1;
          r_cnt  <= w_cnt_nx;
          if (w_cnt_nx == r_post_sh) begin
            r_irq   <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: if (!r_ovalid) begin
          r_ovalid <= 1'b1;
          r_rptr   <= r_wptr;
          r_ocnt   <= '0;
        end else if (sto_tready) begin
          r_rptr   <= r_rptr + 1'b1;
          r_ocnt   <= r_ocnt + 1'b1;
          r_ovalid <= !(&r_ocnt);
          r_state  <= &r_ocnt ? S_IDLE : S_READ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_capture.sv
// tb_capture: scoreboard bench for capture with DEPTH=16 and an incrementing sample stream.
module tb_capture;
  logic        clk, rst;
  logic        bus_wready, bus_wvalid;
  logic [7:0]  bus_waddr;
  logic [31:0] bus_wdata;
  logic        sti_tready, sti_tvalid;
  logic [31:0] sti_tevent, sti_tdata;
  logic        sto_tready, sto_tvalid, sto_tlast;
  logic [31:0] sto_tevent, sto_tdata;
  logic        acq_busy, acq_irq;
  int          nvec = 0, nbad = 0, irqs = 0, smp = 0;
  int          trig_a = -1, trig_b = -1;
  logic [31:0] ev_a = '0, ev_b = '0;
  logic        rdy_rand = 1'b0, hold_pend = 1'b0;
  logic [32:0] hold_v;
  logic [32:0] exp_q[$];
  capture #(.BAW(8), .BDW(32), .SDW(32), .SEW(32), .MAW(4)) dut (
    .clk(clk), .rst(rst),
    .bus_wready(bus_wready), .bus_wvalid(bus_wvalid), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
    .sti_tready(sti_tready), .sti_tvalid(sti_tvalid), .sti_tevent(sti_tevent), .sti_tdata(sti_tdata),
    .sto_tready(sto_tready), .sto_tvalid(sto_tvalid), .sto_tlast(sto_tlast),
    .sto_tevent(sto_tevent), .sto_tdata(sto_tdata),
    .acq_busy(acq_busy), .acq_irq(acq_irq)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive_beat();
    sti_tvalid = 1'b1;
    sti_tdata  = 32'(smp);
    sti_tevent = smp == trig_a ? ev_a : smp == trig_b ? ev_b : '0;
    smp++;
  endtask
  task automatic cyc();
    logic [32:0] e;
    @(negedge clk);
    if (acq_irq) irqs++;
    sto_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (sto_tvalid) begin
      if (hold_pend) chk("stall_stable", 64'({sto_tlast, sto_tdata}), 64'(hold_v));
      if (sto_tready) begin
        if (exp_q.size() == 0) chk("extra_beat", 64'(sto_tvalid), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("beat", 64'({sto_tlast, sto_tdata}), 64'(e));
        end
        hold_pend = 1'b0;
      end else begin
        hold_pend = 1'b1;
        hold_v = {sto_tlast, sto_tdata};
      end
    end else hold_pend = 1'b0;
    drive_beat();
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_wvalid = 1'b1;
    bus_waddr  = a;
    bus_wdata  = d;
    cyc();
    bus_wvalid = 1'b0;
  endtask
  task automatic setup(input logic [31:0] mask, input int post, input int ta, input logic [31:0] ea,
                       input int tb, input logic [31:0] eb);
    wr(8'h01, mask);
    wr(8'h02, 32'(post));
    trig_a = ta; ev_a = ea; trig_b = tb; ev_b = eb;
    smp = 0;
    drive_beat();
  endtask
  task automatic push_window(input int last_smp);
    for (int k = 0; k < 16; k++) exp_q.push_back({k == 15, 32'(last_smp - 15 + k)});
  endtask
  task automatic run(input string tag, input logic [31:0] mask, input int post, input int ta,
                     input logic [31:0] ea, input int tb, input logic [31:0] eb, input int tw);
    int irq0, n;
    setup(mask, post, ta, ea, tb, eb);
    push_window(tw + post);
    irq0 = irqs;
    wr(8'h00, 32'h1);
    n = 0;
    while ((exp_q.size() != 0 || acq_busy) && n < 400) begin cyc(); n++; end
    chk({tag, "_in_time"}, 64'(n < 400), 64'd1);
    chk({tag, "_irq"}, 64'(irqs - irq0), 64'd1);
    exp_q.delete();
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_tvalid"}, 64'(sto_tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(sto_tlast), 64'd0);
    chk({tag, "_tdata"}, 64'(sto_tdata), 64'd0);
    chk({tag, "_tevent"}, 64'(sto_tevent), 64'd0);
    chk({tag, "_busy"}, 64'(acq_busy), 64'd0);
    chk({tag, "_irq"}, 64'(acq_irq), 64'd0);
    chk({tag, "_sti_tready"}, 64'(sti_tready), 64'd1);
    chk({tag, "_bus_wready"}, 64'(bus_wready), 64'd1);
  endtask
  initial begin
    int irq0, n;
    rst = 1'b0; bus_wvalid = 1'b0; bus_waddr = '0; bus_wdata = '0;
    sto_tready = 1'b1; sti_tvalid = 1'b0; sti_tdata = '0; sti_tevent = '0;
    cyc(); cyc();
    chk_reset("reset");
    rst = 1'b1;
    cyc();
    // Basic window with post-trigger history.
    run("t1", 32'h1, 5, 40, 32'h1, -1, 32'h0, 40);
    // POST=0 makes the trigger beat the last one; a masked-off event must not trigger.
    run("t2", 32'h2, 0, 20, 32'h2, 17, 32'h1, 20);
    // Trigger during FILL is ignored.
    run("t3", 32'h1, 5, 3, 32'h1, 25, 32'h1, 25);
    rdy_rand = 1'b1;
    run("t4", 32'h1, 7, 30, 32'h1, -1, 32'h0, 30);
    rdy_rand = 1'b0;
    // Abort in the middle of POST.
    setup(32'h1, 10, 20, 32'h1, -1, 32'h0);
    irq0 = irqs;
    wr(8'h00, 32'h1);
    n = 0;
    while (smp < 25 && n < 100) begin cyc(); n++; end
    chk("t5_busy_before_abort", 64'(acq_busy), 64'd1);
    wr(8'h00, 32'h2);
    chk("t5_abort_busy", 64'(acq_busy), 64'd0);
    chk("t5_abort_tvalid", 64'(sto_tvalid), 64'd0);
    repeat (40) cyc();
    chk("t5_no_irq", 64'(irqs - irq0), 64'd0);
    chk("t5_idle", 64'(acq_busy), 64'd0);
    run("t5b", 32'h1, 5, 40, 32'h1, -1, 32'h0, 40);
    // Reset pulse in the middle of READ.
    setup(32'h1, 3, 20, 32'h1, -1, 32'h0);
    push_window(23);
    wr(8'h00, 32'h1);
    n = 0;
    while (exp_q.size() > 10 && n < 200) begin cyc(); n++; end
    chk("t6_reached_read", 64'(sto_tvalid), 64'd1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk_reset("t6");
    exp_q.delete();
    repeat (20) cyc();
    chk("t6_stays_idle", 64'(acq_busy), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
